// File: rtl/debug_ram_pkg.sv
// rtl/debug_ram_pkg.sv - shared widths, arbiter state encoding and helpers
package debug_ram_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        RDWAIT  = 2'd2
    } arb_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/debug_ram_arbiter_starve_counter.sv
// rtl/debug_ram_arbiter_starve_counter.sv - saturating counter with clear and sticky limit flag
module starve_counter #(
    parameter int CNT_W = 13,
    parameter int LIMIT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             flag
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (inc && (count != LIM)) begin
            count_nxt = count + 1'b1;
        end
    end

    // The flag only ever sets; a clear of the count leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            flag  <= 1'b0;
        end else begin
            count <= count_nxt;
            if (count_nxt == LIM) begin
                flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_ram_arbiter.sv
// rtl/debug_ram_arbiter.sv - display-priority arbiter for the debug RAM; optional stats via DEBUG_RAM_ARB_STATS_EN
module debug_ram_arbiter
    import debug_ram_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_starved,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef DEBUG_RAM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_host_wr,
    output logic [15:0]       stat_host_rd,
    output logic [15:0]       stat_max_wait
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state;
    logic              hold_we;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic              accept;
    logic              issue;
    logic [CNT_W-1:0]  unused_starve_cnt;

    assign host_ready = (state == EMPTY);
    assign accept     = host_ready && host_valid;
    // Gating with rst_n keeps a request caught mid-reset from reaching the RAM.
    assign issue      = rst_n && (state == PENDING) && !disp_req;
    assign disp_rdata = ram_rdata;

    always_comb begin
        ram_addr  = disp_addr;
        ram_we    = 1'b0;
        ram_wdata = hold_wdata;
        if (issue) begin
            ram_addr = hold_addr;
            ram_we   = hold_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            hold_we     <= 1'b0;
            hold_addr   <= '0;
            hold_wdata  <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= 1'b0;
            case (state)
                EMPTY: begin
                    if (host_valid) begin
                        hold_we    <= host_we;
                        hold_addr  <= host_addr;
                        hold_wdata <= host_wdata;
                        state      <= PENDING;
                    end
                end
                PENDING: begin
                    if (!disp_req) begin
                        state <= hold_we ? EMPTY : RDWAIT;
                    end
                end
                RDWAIT: begin
                    // ram_rdata belongs to last cycle's host address even if the display reads now.
                    host_rdata  <= ram_rdata;
                    host_rvalid <= 1'b1;
                    state       <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    starve_counter #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (issue),
        .inc   ((state == PENDING) && disp_req),
        .count (unused_starve_cnt),
        .flag  (host_starved)
    );

`ifdef DEBUG_RAM_ARB_STATS_EN
    logic [15:0] wait_cnt;
    logic [15:0] wait_total;
    logic        unused_wait_flag;

    starve_counter #(
        .CNT_W (16),
        .LIMIT (65535)
    ) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (state == PENDING),
        .count (wait_cnt),
        .flag  (unused_wait_flag)
    );

    // Count includes the issue cycle itself.
    assign wait_total = sat_inc16(wait_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_host_wr  <= '0;
            stat_host_rd  <= '0;
            stat_max_wait <= '0;
        end else if (issue) begin
            if (hold_we) begin
                stat_host_wr <= sat_inc16(stat_host_wr);
            end else begin
                stat_host_rd <= sat_inc16(stat_host_rd);
            end
            if (wait_total > stat_max_wait) begin
                stat_max_wait <= wait_total;
            end
        end
    end
`endif

endmodule

// File: tb/tb_debug_ram_arbiter.sv
// tb/tb_debug_ram_arbiter.sv - directed vector bench for debug_ram_arbiter with a RAM model
module tb_debug_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       disp_req;
    logic [9:0] disp_addr;
    logic [7:0] disp_rdata;
    logic       host_valid;
    logic       host_ready;
    logic       host_we;
    logic [9:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       host_starved;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [7:0] mem [0:1023];
    logic       mem_init;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    debug_ram_arbiter #(
        .ADDR_W       (10),
        .DATA_W       (8),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_rdata   (disp_rdata),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .host_starved (host_starved),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 8'(k) ^ 8'h5A;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic       dr;
        logic [9:0] da;
        logic       hv;
        logic       hw;
        logic [9:0] ha;
        logic [7:0] hd;
        logic       e_rdy;
        logic       e_we;
        logic [9:0] e_addr;
        logic [7:0] e_wd;
        logic       e_rv;
        logic [7:0] e_rd;
        logic       e_st;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(input logic dr, input logic [9:0] da, input logic hv,
                                input logic hw, input logic [9:0] ha, input logic [7:0] hd,
                                input logic e_rdy, input logic e_we, input logic [9:0] e_addr,
                                input logic [7:0] e_wd, input logic e_rv, input logic [7:0] e_rd,
                                input logic e_st);
        vec_t v;
        v.dr = dr; v.da = da; v.hv = hv; v.hw = hw; v.ha = ha; v.hd = hd;
        v.e_rdy = e_rdy; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_rv = e_rv; v.e_rd = e_rd; v.e_st = e_st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dr, input logic [9:0] da, input logic hv,
                         input logic hw, input logic [9:0] ha, input logic [7:0] hd);
        disp_req = dr; disp_addr = da; host_valid = hv;
        host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    initial begin
        //              dr  da      hv  hw  ha      hd     rdy we  addr    wd     rv  rd     st
        vecs[0]  = mk(0, 10'h000, 1, 1, 10'h123, 8'hA5, 1, 0, 10'h000, 8'h00, 0, 8'h00, 0);
        vecs[1]  = mk(0, 10'h000, 0, 0, 10'h000, 8'h00, 0, 1, 10'h123, 8'hA5, 0, 8'h00, 0);
        vecs[2]  = mk(0, 10'h000, 1, 0, 10'h123, 8'h00, 1, 0, 10'h000, 8'h00, 0, 8'h00, 0);
        vecs[3]  = mk(0, 10'h000, 0, 0, 10'h000, 8'h00, 0, 0, 10'h123, 8'h00, 0, 8'h00, 0);
        vecs[4]  = mk(0, 10'h055, 0, 0, 10'h000, 8'h00, 0, 0, 10'h055, 8'h00, 0, 8'h00, 0);
        vecs[5]  = mk(0, 10'h055, 0, 0, 10'h000, 8'h00, 1, 0, 10'h055, 8'h00, 1, 8'hA5, 0);
        vecs[6]  = mk(0, 10'h055, 1, 1, 10'h200, 8'h3C, 1, 0, 10'h055, 8'h00, 0, 8'hA5, 0);
        for (int k = 0; k < 5; k++)
            vecs[7 + k] = mk(1, 10'h100 + 10'(k), 0, 0, 10'h000, 8'h00,
                             0, 0, 10'h100 + 10'(k), 8'h00, 0, 8'hA5, 0);
        vecs[12] = mk(0, 10'h001, 0, 0, 10'h000, 8'h00, 0, 1, 10'h200, 8'h3C, 0, 8'hA5, 0);
        vecs[13] = mk(0, 10'h001, 1, 1, 10'h201, 8'h4D, 1, 0, 10'h001, 8'h00, 0, 8'hA5, 0);
        for (int k = 0; k < 5; k++)
            vecs[14 + k] = mk(1, 10'h180 + 10'(k), 0, 0, 10'h000, 8'h00,
                              0, 0, 10'h180 + 10'(k), 8'h00, 0, 8'hA5, 0);
        vecs[19] = mk(0, 10'h002, 0, 0, 10'h000, 8'h00, 0, 1, 10'h201, 8'h4D, 0, 8'hA5, 0);
        vecs[20] = mk(0, 10'h002, 1, 0, 10'h200, 8'h00, 1, 0, 10'h002, 8'h00, 0, 8'hA5, 0);
        vecs[21] = mk(1, 10'h010, 0, 0, 10'h000, 8'h00, 0, 0, 10'h010, 8'h00, 0, 8'hA5, 0);
        vecs[22] = mk(0, 10'h010, 0, 0, 10'h000, 8'h00, 0, 0, 10'h200, 8'h00, 0, 8'hA5, 0);
        vecs[23] = mk(0, 10'h010, 0, 0, 10'h000, 8'h00, 0, 0, 10'h010, 8'h00, 0, 8'hA5, 0);
        vecs[24] = mk(0, 10'h010, 0, 0, 10'h000, 8'h00, 1, 0, 10'h010, 8'h00, 1, 8'h3C, 0);

        mem_init = 1'b1;
        rst_n    = 1'b0;
        drive(0, 10'h000, 0, 0, 10'h000, 8'h00);
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        #1;
        check("reset host_ready", host_ready, 1);
        check("reset host_rvalid", host_rvalid, 0);
        check("reset host_rdata", host_rdata, 0);
        check("reset host_starved", host_starved, 0);
        check("reset ram_we", ram_we, 0);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            drive(vecs[i].dr, vecs[i].da, vecs[i].hv, vecs[i].hw, vecs[i].ha, vecs[i].hd);
            #1;
            check($sformatf("row%0d host_ready", i), host_ready, vecs[i].e_rdy);
            check($sformatf("row%0d ram_we", i), ram_we, vecs[i].e_we);
            check($sformatf("row%0d ram_addr", i), ram_addr, vecs[i].e_addr);
            check($sformatf("row%0d host_rvalid", i), host_rvalid, vecs[i].e_rv);
            check($sformatf("row%0d host_rdata", i), host_rdata, vecs[i].e_rd);
            check($sformatf("row%0d host_starved", i), host_starved, vecs[i].e_st);
            if (vecs[i].e_we) check($sformatf("row%0d ram_wdata", i), ram_wdata, vecs[i].e_wd);
        end

        // Long display burst with a write pending: starvation at the 8th blocked cycle.
        @(negedge clk);
        drive(0, 10'h000, 1, 1, 10'h300, 8'h77);
        #1 check("starve accept ready", host_ready, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1, 10'(i * 3 + 5), 0, 0, 10'h000, 8'h00);
            #1;
            check($sformatf("burst%0d ram_addr", i), ram_addr, 10'(i * 3 + 5));
            check($sformatf("burst%0d ram_we", i), ram_we, 0);
            check($sformatf("burst%0d host_ready", i), host_ready, 0);
            check($sformatf("burst%0d host_starved", i), host_starved, (i >= 8) ? 1 : 0);
        end
        @(negedge clk);
        drive(0, 10'h000, 0, 0, 10'h000, 8'h00);
        #1;
        check("burst issue ram_we", ram_we, 1);
        check("burst issue ram_addr", ram_addr, 10'h300);
        check("burst issue ram_wdata", ram_wdata, 8'h77);
        check("burst issue starved", host_starved, 1);
        @(negedge clk);
        #1;
        check("after burst ready", host_ready, 1);
        check("after burst starved sticky", host_starved, 1);

        // RDWAIT overlapping a display read.
        @(negedge clk);
        drive(0, 10'h000, 1, 0, 10'h123, 8'h00);
        @(negedge clk);
        drive(0, 10'h000, 0, 0, 10'h000, 8'h00);
        #1 check("ovl issue ram_addr", ram_addr, 10'h123);
        @(negedge clk);
        drive(1, 10'h010, 0, 0, 10'h000, 8'h00);
        #1;
        check("ovl rdwait ram_addr", ram_addr, 10'h010);
        check("ovl rdwait ram_we", ram_we, 0);
        @(negedge clk);
        drive(0, 10'h000, 0, 0, 10'h000, 8'h00);
        #1;
        check("ovl host_rvalid", host_rvalid, 1);
        check("ovl host_rdata", host_rdata, 8'hA5);
        check("ovl disp_rdata", disp_rdata, 8'h4A);

        // Reset while a write is pending: it must never reach the RAM.
        @(negedge clk);
        drive(0, 10'h000, 1, 1, 10'h050, 8'hEE);
        @(negedge clk);
        drive(0, 10'h000, 0, 0, 10'h000, 8'h00);
        rst_n = 1'b0;
        #1 check("rst pending ram_we", ram_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst pending ready", host_ready, 1);
        check("rst pending rvalid", host_rvalid, 0);
        check("rst pending rdata", host_rdata, 0);
        check("rst pending starved cleared", host_starved, 0);
        check("rst pending ram_we after", ram_we, 0);
        @(negedge clk);
        #1 check("rst pending mem untouched", mem[10'h050], 8'h0A);

        // Reset in RDWAIT: no read response.
        @(negedge clk);
        drive(0, 10'h000, 1, 0, 10'h123, 8'h00);
        @(negedge clk);
        drive(0, 10'h000, 0, 0, 10'h000, 8'h00);
        #1 check("rst rdwait issue addr", ram_addr, 10'h123);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst rdwait rvalid", host_rvalid, 0);
        check("rst rdwait ready", host_ready, 1);
        check("rst rdwait rdata", host_rdata, 0);
        @(negedge clk);
        #1 check("rst rdwait rvalid later", host_rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
